muldiv_ctrl: RTL

- Sequencing controller for the EX-stage multiply/divide resources.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time from EX and drives the fixed-latency multiplier and the start/ready iterative divider.
- Holds the pipeline via stallreq while busy and returns a 64-bit {hi, lo} result with a one-cycle valid for the HI/LO write path.

---
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiply/divide resources: issues one op, stalls EX, returns {hi, lo}.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero completes without the divider (hi=src1, lo=all ones).
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_start,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;
    logic             issue;

    assign issue  = op_valid & ~flush;
    assign res_hi = hi_q;
    assign res_lo = lo_q;

    // State, latched operands, latency counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sgn_q <= sgn_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Next-state and resource drive; flush wins over every transition
    always_comb begin
        state_d     = state;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        stallreq    = 1'b0;
        res_valid   = 1'b0;
        mul_signed  = 1'b0;
        mul_ina     = '0;
        mul_inb     = '0;
        div_signed  = 1'b0;
        div_opdata1 = '0;
        div_opdata2 = '0;
        div_start   = 1'b0;
        div_annul   = 1'b0;

        case (state)
            IDLE: begin
                stallreq = issue;
                if (issue) begin
                    a_d   = src1;
                    b_d   = src2;
                    sgn_d = ~op_code[0];
                    if (!op_code[1]) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_W'(MUL_LAT);
                    end else begin
`ifdef MULDIV_DIV0_FAST_EN
                        if (src2 == '0) begin
                            state_d = DONE;
                            hi_d    = src1;
                            lo_d    = '1;
                        end else begin
                            state_d = DIV_WAIT;
                        end
`else
                        state_d = DIV_WAIT;
`endif
                    end
                end
            end

            MUL_WAIT: begin
                stallreq   = 1'b1;
                mul_signed = sgn_q;
                mul_ina    = a_q;
                mul_inb    = b_q;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DIV_WAIT: begin
                stallreq    = 1'b1;
                div_signed  = sgn_q;
                div_opdata1 = a_q;
                div_opdata2 = b_q;
                if (flush) begin
                    // Reset wipes the divider itself, so no abort pulse then
                    div_annul = ~rst;
                    state_d   = IDLE;
                end else begin
                    div_start = 1'b1;
                    if (div_ready) begin
                        hi_d    = div_result[63:32];
                        lo_d    = div_result[31:0];
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // op_valid here is the completing instruction; never reissue it
                res_valid = ~flush;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
